// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall sequencer for the 5-stage RV32I pipeline. It produces the
// PC / IF/ID / ID/EX hold, the ID/EX bubble and the IF/ID flush controls, and
// the ID-stage early-branch forwarding selects. A four-state FSM covers the
// data-memory wait, load-use and branch-operand stalls, and the trap
// redirect drain. A free-running counter records the number of PC-hold cycles.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2       source register indices of the ID instruction
//   id_use_rs1/rs2      ID instruction actually reads that operand
//   id_is_cond_branch   ID holds a conditional branch (resolved in ID)
//   ex_wreg/regwrite/memread   destination info of the EX instruction
//   mem_wreg/regwrite/memread  destination info of the MEM instruction
//   dmem_req/dmem_ready data-memory handshake of the MEM stage
//   branch_taken_id     early branch taken in ID
//   trap_ex             ecall/mret in EX, redirect issued this cycle
//   pc_keep, keep, nop, flush_ifid   pipeline control outputs
//   fwd_ex_sel/fwd_mem_sel  [1]=rs1, [0]=rs2 forwarding selects for ID
//   state               current FSM state (debug)
//   stall_cnt           count of cycles with pc_keep=1
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned TRAP_DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_cond_branch,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_wreg,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             branch_taken_id,
    input  logic             trap_ex,
    output logic             pc_keep,
    output logic             keep,
    output logic             nop,
    output logic             flush_ifid,
    output logic [1:0]       fwd_ex_sel,
    output logic [1:0]       fwd_mem_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_LDSTALL    = 2'd2,
        ST_TRAP_DRAIN = 2'd3
    } state_e;

    localparam logic [2:0] DRAIN_INIT = 3'(TRAP_DRAIN_CYCLES - 1);

    // A producing stage hits an operand when it writes the register the ID
    // instruction reads; x0 is hard-wired and never hits.
    function automatic logic reg_hit(input logic use_op, input logic wr_en,
                                     input logic [4:0] wreg, input logic [4:0] rs);
        reg_hit = use_op && wr_en && (wreg == rs) && (rs != 5'd0);
    endfunction

    state_e           state_q, state_d;
    state_e           sv_state_q, sv_state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       sv_cnt_q, sv_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s;
    logic mem_stall_s, load_use_s, br_mem_load_s;
    logic pc_keep_s, keep_s, nop_s, flush_s;

    assign ex_hit1_s  = reg_hit(id_use_rs1, ex_regwrite,  ex_wreg,  id_rs1);
    assign ex_hit2_s  = reg_hit(id_use_rs2, ex_regwrite,  ex_wreg,  id_rs2);
    assign mem_hit1_s = reg_hit(id_use_rs1, mem_regwrite, mem_wreg, id_rs1);
    assign mem_hit2_s = reg_hit(id_use_rs2, mem_regwrite, mem_wreg, id_rs2);

    assign mem_stall_s   = dmem_req && !dmem_ready;
    assign load_use_s    = (ex_hit1_s || ex_hit2_s) && ex_memread;
    assign br_mem_load_s = (mem_hit1_s || mem_hit2_s) && mem_memread && id_is_cond_branch;

    // Next-state and control decode; memory wait outranks everything and
    // parks the interrupted state/count so it can resume afterwards.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sv_state_d = sv_state_q;
        sv_cnt_d   = sv_cnt_q;
        pc_keep_s  = 1'b0;
        keep_s     = 1'b0;
        nop_s      = 1'b0;
        flush_s    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_s) begin
                    pc_keep_s  = 1'b1;
                    keep_s     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    sv_state_d = ST_RUN;
                    sv_cnt_d   = 3'd0;
                end else if (trap_ex) begin
                    flush_s = 1'b1;
                    nop_s   = 1'b1;
                    state_d = ST_TRAP_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end else if (load_use_s) begin
                    pc_keep_s = 1'b1;
                    keep_s    = 1'b1;
                    nop_s     = 1'b1;
                    // A branch also needs the load out of MEM before it can
                    // compare in ID, hence the extra LDSTALL cycle.
                    if (id_is_cond_branch) begin
                        state_d = ST_LDSTALL;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (br_mem_load_s) begin
                    pc_keep_s = 1'b1;
                    keep_s    = 1'b1;
                    nop_s     = 1'b1;
                end else if (branch_taken_id) begin
                    flush_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // The completing cycle releases the pipeline; the saved state
                // takes over from the next cycle.
                if (dmem_ready) begin
                    state_d = sv_state_q;
                    cnt_d   = sv_cnt_q;
                end else begin
                    pc_keep_s = 1'b1;
                    keep_s    = 1'b1;
                end
            end
            ST_LDSTALL: begin
                if (mem_stall_s) begin
                    pc_keep_s  = 1'b1;
                    keep_s     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    sv_state_d = ST_LDSTALL;
                    sv_cnt_d   = cnt_q;
                end else begin
                    pc_keep_s = 1'b1;
                    keep_s    = 1'b1;
                    nop_s     = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_TRAP_DRAIN: begin
                // trap_ex is deliberately not looked at while draining.
                if (mem_stall_s) begin
                    pc_keep_s  = 1'b1;
                    keep_s     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    sv_state_d = ST_TRAP_DRAIN;
                    sv_cnt_d   = cnt_q;
                end else begin
                    flush_s = 1'b1;
                    nop_s   = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // FSM, saved-context and stall-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= 3'd0;
            sv_state_q  <= ST_RUN;
            sv_cnt_q    <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sv_state_q <= sv_state_d;
            sv_cnt_q   <= sv_cnt_d;
            if (pc_keep_s) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    // Reset overrides the controls combinationally so the pipeline is
    // flushed and bubbled immediately, without waiting for a clock edge.
    assign pc_keep        = rst ? 1'b0 : pc_keep_s;
    assign keep           = rst ? 1'b0 : keep_s;
    assign nop            = rst ? 1'b1 : nop_s;
    assign flush_ifid     = rst ? 1'b1 : flush_s;
    // Load results are not available yet, so a load never forwards.
    assign fwd_ex_sel[1]  = !rst && ex_hit1_s && !ex_memread;
    assign fwd_ex_sel[0]  = !rst && ex_hit2_s && !ex_memread;
    assign fwd_mem_sel[1] = !rst && mem_hit1_s && !ex_hit1_s && !mem_memread;
    assign fwd_mem_sel[0] = !rst && mem_hit2_s && !ex_hit2_s && !mem_memread;
    assign state          = state_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage RV32I pipeline. It generates the IF/ID hold, ID/EX hold and bubble, and IF/ID flush controls consumed by the fetch and decode stages. It also generates the ID-stage early-branch forwarding selects. A small FSM handles data-memory wait, load-use and branch-operand stalls, and trap (ecall/mret) redirect drains; a 32-bit counter records stall cycles.

Parameters:
TRAP_DRAIN_CYCLES, 2, cycles the IF/ID and ID/EX stages are flushed after a trap redirect (1..7).
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_is_cond_branch  input  1  ID holds beq/bne/blt/bge/bltu/bgeu (resolves early in ID)
ex_wreg  input  5  destination register of the instruction in EX
ex_regwrite  input  1  EX instruction writes a register
ex_memread  input  1  EX instruction is a load
mem_wreg  input  5  destination register of the instruction in MEM
mem_regwrite  input  1  MEM instruction writes a register
mem_memread  input  1  MEM instruction is a load
dmem_req  input  1  MEM stage has an outstanding data access
dmem_ready  input  1  data memory completes the access this cycle
branch_taken_id  input  1  early branch taken in ID
trap_ex  input  1  ecall or mret is in EX (redirect issued this cycle)
pc_keep  output  1  hold the PC
keep  output  1  hold IF/ID and ID/EX (decode keep input)
nop  output  1  insert a bubble into ID/EX (decode nop input)
flush_ifid  output  1  replace the IF/ID instruction with a nop
fwd_ex_sel  output  2  [1]=rs1, [0]=rs2 take the EX result in ID
fwd_mem_sel  output  2  [1]=rs1, [0]=rs2 take the MEM result in ID
state  output  2  current FSM state (debug)
stall_cnt  output  CNT_W  number of cycles with pc_keep=1

Behaviour:
- FSM states: RUN=0, MEM_WAIT=1, LDSTALL=2, TRAP_DRAIN=3. A 3-bit down-counter cnt sits alongside the state.
- Reset (rst=1, asynchronous): state=RUN, cnt=0, stall_cnt=0. Outputs while reset is asserted: pc_keep=0, keep=0, nop=1, flush_ifid=1, fwd selects=0.
- Match definition. rs1 hits EX when id_use_rs1 && ex_regwrite && ex_wreg==id_rs1 && id_rs1!=0; the same pattern applies to rs2 and to MEM. Register x0 never hits.
- Forwarding selects are purely combinational.
  - fwd_ex_sel[i] = EX hit on operand i.
  - fwd_mem_sel[i] = MEM hit on operand i && !EX hit on operand i, so EX takes priority.
  - Both selects are forced to 0 when the hitting stage's instruction is a load, because that data is not ready.
- Condition priority, evaluated every cycle in RUN, highest first:
  1. dmem_req && !dmem_ready: enter MEM_WAIT.
     - Outputs this cycle and every MEM_WAIT cycle: pc_keep=1, keep=1, nop=0, flush_ifid=0.
     - Exit to RUN on the first cycle dmem_ready=1; that cycle outputs no stall.
  2. trap_ex: flush_ifid=1, nop=1, pc_keep=0. Enter TRAP_DRAIN with cnt=TRAP_DRAIN_CYCLES-1.
     - TRAP_DRAIN holds flush_ifid=1 and nop=1 each cycle and decrements cnt.
     - At cnt==0 the FSM goes to RUN.
     - Any trap_ex arriving during TRAP_DRAIN is ignored.
  3. Load-use hazard: EX hit with ex_memread.
     - Outputs pc_keep=1, keep=1 (IF/ID hold), nop=1 (bubble into ID/EX), so nop overrides keep for ID/EX.
     - Non-branch ID instruction: 1 cycle, stays in RUN.
     - id_is_cond_branch=1: 2 cycles, goes to LDSTALL with cnt=0; LDSTALL emits the same outputs for one more cycle, then returns to RUN.
  4. Branch operand from a MEM load (MEM hit with mem_memread && id_is_cond_branch): 1 stall cycle with the same outputs as item 3.
  5. branch_taken_id (with no stall active): flush_ifid=1 for that cycle only.
- dmem_req && !dmem_ready during LDSTALL or TRAP_DRAIN:
  - The FSM moves to MEM_WAIT and saves the interrupted state and cnt.
  - It resumes the saved state on dmem_ready.
  - While in MEM_WAIT, nop=0 and flush_ifid=0.
- stall_cnt increments by 1 every cycle pc_keep=1, wraps modulo 2^CNT_W, and is not reset except by rst.
- rst asserted mid-stall or mid-drain aborts immediately to the reset values.

Test Plan:
- lw x5,0(x1) in EX, add x6,x5,x2 in ID -> pc_keep=keep=nop=1 for exactly 1 cycle; next cycle fwd_mem_sel=2'b00 with load in MEM; stall_cnt=1.
- lw x5 in EX, beq x5,x0 in ID -> 2 stall cycles (RUN->LDSTALL->RUN); then beq reads forwarded value; stall_cnt=2.
- add x7 in EX and add x7 in MEM, ID reads rs1=x7,rs2=x7 -> fwd_ex_sel=2'b11, fwd_mem_sel=2'b00; ID rs1=x0 with ex_wreg=0 -> both selects 0.
- dmem_req=1, dmem_ready=0 for 3 cycles during an LDSTALL -> state=1 for 3 cycles with keep=1, nop=0; after ready, LDSTALL resumes for its remaining cycle.
- trap_ex pulse with TRAP_DRAIN_CYCLES=2 -> flush_ifid=nop=1 for 3 cycles total (trigger + 2 drain); a second trap_ex during drain is ignored.
- Assert rst during MEM_WAIT -> state=0, stall_cnt=0, nop=1 and flush_ifid=1 immediately, without waiting for clk.
